// File: rtl/zbus_strobes_pkg.sv
// zbus_strobes_pkg
//   Shared definitions for the Z80 bus-cycle decoder. The state encoding and
//   the decode priority order live here so that the arbiter can reuse them
//   for its debug state output.
//   Contents:
//     zstate_e   - decoded bus-cycle states
//     zstrb_t    - packed bundle of the raw active-low Z80 strobes
//     zdecode()  - sampled-strobe decode in priority order
//     zactive()  - 1 for states that represent a real (active) cycle
package zbus_strobes_pkg;

  typedef enum logic [3:0] {
    ZST_IDLE     = 4'd0,
    ZST_PEND_MEM = 4'd1,
    ZST_PEND_IO  = 4'd2,
    ZST_MEM_RD   = 4'd3,
    ZST_MEM_WR   = 4'd4,
    ZST_IO_RD    = 4'd5,
    ZST_IO_WR    = 4'd6,
    ZST_INTACK   = 4'd7,
    ZST_RFSH     = 4'd8
  } zstate_e;

  typedef struct packed {
    logic mreq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic m1_n;
    logic rfsh_n;
  } zstrb_t;

  localparam zstrb_t ZSTRB_IDLE = '{mreq_n: 1'b1, iorq_n: 1'b1, rd_n: 1'b1,
                                    wr_n: 1'b1, m1_n: 1'b1, rfsh_n: 1'b1};

  // Order matters: refresh wins over a read/write on MREQ, and M1 on IORQ
  // marks an interrupt acknowledge even if RD were also low.
  function automatic zstate_e zdecode(input zstrb_t s);
    zstate_e st;
    if (!s.mreq_n && !s.rfsh_n)     st = ZST_RFSH;
    else if (!s.mreq_n && !s.rd_n)  st = ZST_MEM_RD;
    else if (!s.mreq_n && !s.wr_n)  st = ZST_MEM_WR;
    else if (!s.mreq_n)             st = ZST_PEND_MEM;
    else if (!s.iorq_n && !s.m1_n)  st = ZST_INTACK;
    else if (!s.iorq_n && !s.rd_n)  st = ZST_IO_RD;
    else if (!s.iorq_n && !s.wr_n)  st = ZST_IO_WR;
    else if (!s.iorq_n)             st = ZST_PEND_IO;
    else                            st = ZST_IDLE;
    return st;
  endfunction

  function automatic logic zactive(input zstate_e st);
    return !(st == ZST_IDLE || st == ZST_PEND_MEM || st == ZST_PEND_IO);
  endfunction

endpackage

// File: rtl/zbus_strobes_sample.sv
// zbus_strobes_sample
//   Captures the raw Z80 strobes and address only on fclk edges flagged by
//   the clock generator (zpos/zneg), where the Z80 outputs are stable, and
//   raises a one-cycle valid flag the cycle after each capture.
//   Ports:
//     clk_i, rst_ni        - system clock, synchronous active-low reset
//     zpos_i, zneg_i       - Z80 clock edge strobes (either one samples)
//     za_i, strb_i         - raw address bus and strobes
//     smp_addr_o, smp_strb_o - sampled address and strobes
//     smp_v_o              - one-cycle flag: a new sample is available
module zbus_strobes_sample
  import zbus_strobes_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              zpos_i,
  input  logic              zneg_i,
  input  logic [ADDR_W-1:0] za_i,
  input  zstrb_t            strb_i,
  output logic [ADDR_W-1:0] smp_addr_o,
  output zstrb_t            smp_strb_o,
  output logic              smp_v_o
);

  logic [ADDR_W-1:0] addr_q;
  zstrb_t            strb_q;
  logic              smp_v_q;

  // Both strobes at once collapses into a single sample.
  logic take;
  assign take = zpos_i | zneg_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      strb_q  <= ZSTRB_IDLE;
      smp_v_q <= 1'b0;
    end else begin
      smp_v_q <= take;
      if (take) begin
        addr_q <= za_i;
        strb_q <= strb_i;
      end
    end
  end

  assign smp_addr_o = addr_q;
  assign smp_strb_o = strb_q;
  assign smp_v_o    = smp_v_q;

endmodule

// File: rtl/zbus_strobes.sv
// zbus_strobes
//   Turns the sampled Z80 control strobes into single-fclk start/end pulses
//   for memory read/write, IO read/write, interrupt acknowledge and refresh
//   cycles, so downstream logic never sees the raw asynchronous strobes.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   IDLE       | no cycle on the bus
//   PEND_MEM   | MREQ low, RD/WR not yet decided (no pulse, not busy)
//   PEND_IO    | IORQ low, direction not yet decided (no pulse, not busy)
//   MEM_RD     | memory read (opfetch marks an M1 fetch)
//   MEM_WR     | memory write
//   IO_RD      | IO read
//   IO_WR      | IO write
//   INTACK     | interrupt acknowledge (IORQ with M1)
//   RFSH       | DRAM refresh
//
//   Ports:
//     fclk, rst_n          - system clock, synchronous active-low reset
//     zpos, zneg           - Z80 clock edge strobes from the clock generator
//     za                   - Z80 address bus
//     mreq_n..rfsh_n       - raw Z80 strobes
//     *_start              - one-fclk start pulses per cycle type
//     cyc_end              - one-fclk pulse when an active cycle ends
//     opfetch              - M1 opcode fetch qualifier, held until cyc_end
//     cyc_addr             - address latched with the start pulse
//     busy                 - an active (non-pending) cycle is in progress
module zbus_strobes
  import zbus_strobes_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              fclk,
  input  logic              rst_n,
  input  logic              zpos,
  input  logic              zneg,
  input  logic [ADDR_W-1:0] za,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              m1_n,
  input  logic              rfsh_n,
  output logic              mrd_start,
  output logic              mwr_start,
  output logic              iord_start,
  output logic              iowr_start,
  output logic              intack_start,
  output logic              rfsh_start,
  output logic              cyc_end,
  output logic              opfetch,
  output logic [ADDR_W-1:0] cyc_addr,
  output logic              busy
);

  zstrb_t            strb_raw;
  zstrb_t            smp_strb;
  logic [ADDR_W-1:0] smp_addr;
  logic              smp_v;

  assign strb_raw = '{mreq_n: mreq_n, iorq_n: iorq_n, rd_n: rd_n,
                      wr_n: wr_n, m1_n: m1_n, rfsh_n: rfsh_n};

  zbus_strobes_sample #(
    .ADDR_W (ADDR_W)
  ) u_sample (
    .clk_i      (fclk),
    .rst_ni     (rst_n),
    .zpos_i     (zpos),
    .zneg_i     (zneg),
    .za_i       (za),
    .strb_i     (strb_raw),
    .smp_addr_o (smp_addr),
    .smp_strb_o (smp_strb),
    .smp_v_o    (smp_v)
  );

  // start vector order: {mrd, mwr, iord, iowr, intack, rfsh}
  zstate_e           state_q, state_d;
  logic              armed_q, armed_d;
  logic [5:0]        start_q, start_d;
  logic              end_q, end_d;
  logic              opf_q, opf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;

  zstate_e nxt;
  logic    do_start;

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    start_d  = '0;
    end_d    = 1'b0;
    opf_d    = opf_q;
    addr_d   = addr_q;
    nxt      = state_q;
    do_start = 1'b0;

    if (smp_v) begin
      if (!armed_q) begin
        // Ignore whatever cycle was in flight at reset release; arm only once
        // the bus has been seen with neither MREQ nor IORQ asserted.
        state_d = ZST_IDLE;
        if (smp_strb.mreq_n && smp_strb.iorq_n) armed_d = 1'b1;
      end else begin
        nxt      = zdecode(smp_strb);
        end_d    = zactive(state_q) && (nxt != state_q);
        do_start = zactive(nxt) && (nxt != state_q);
        if (do_start) begin
          unique case (nxt)
            ZST_MEM_RD: start_d = 6'b100000;
            ZST_MEM_WR: start_d = 6'b010000;
            ZST_IO_RD:  start_d = 6'b001000;
            ZST_IO_WR:  start_d = 6'b000100;
            ZST_INTACK: start_d = 6'b000010;
            ZST_RFSH:   start_d = 6'b000001;
            default:    start_d = 6'b000000;
          endcase
          addr_d = smp_addr;
          opf_d  = (nxt == ZST_MEM_RD) && !smp_strb.m1_n;
        end else if (end_d) begin
          opf_d = 1'b0;
        end
        state_d = nxt;
      end
    end

    busy_d = zactive(state_d);
  end

  always_ff @(posedge fclk) begin
    if (!rst_n) begin
      state_q <= ZST_IDLE;
      armed_q <= 1'b0;
      start_q <= '0;
      end_q   <= 1'b0;
      opf_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      start_q <= start_d;
      end_q   <= end_d;
      opf_q   <= opf_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
    end
  end

  assign mrd_start    = start_q[5];
  assign mwr_start    = start_q[4];
  assign iord_start   = start_q[3];
  assign iowr_start   = start_q[2];
  assign intack_start = start_q[1];
  assign rfsh_start   = start_q[0];
  assign cyc_end      = end_q;
  assign opfetch      = opf_q;
  assign cyc_addr     = addr_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_zbus_strobes.sv
module tb_zbus_strobes;

  localparam int ADDR_W = 16;

  // strobe patterns {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n}
  localparam logic [5:0] B_IDLE = 6'b111111;
  localparam logic [5:0] B_MRD  = 6'b010111;
  localparam logic [5:0] B_M1RD = 6'b010101;
  localparam logic [5:0] B_MEM  = 6'b011111;
  localparam logic [5:0] B_MWR  = 6'b011011;
  localparam logic [5:0] B_RFSH = 6'b011110;
  localparam logic [5:0] B_IOWR = 6'b101011;
  localparam logic [5:0] B_IORD = 6'b100111;
  localparam logic [5:0] B_INTA = 6'b101101;

  // pulse vector {mrd, mwr, iord, iowr, intack, rfsh, cyc_end}
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_MRD  = 7'b1000000;
  localparam logic [6:0] P_MWR  = 7'b0100000;
  localparam logic [6:0] P_IORD = 7'b0010000;
  localparam logic [6:0] P_IOWR = 7'b0001000;
  localparam logic [6:0] P_INTA = 7'b0000100;
  localparam logic [6:0] P_RFSH = 7'b0000010;
  localparam logic [6:0] P_END  = 7'b0000001;

  logic              fclk = 1'b0;
  logic              rst_n;
  logic              zpos, zneg;
  logic [ADDR_W-1:0] za;
  logic              mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n;
  logic              mrd_start, mwr_start, iord_start, iowr_start;
  logic              intack_start, rfsh_start, cyc_end, opfetch, busy;
  logic [ADDR_W-1:0] cyc_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 fclk = ~fclk;

  zbus_strobes #(.ADDR_W(ADDR_W)) dut (
    .fclk         (fclk),
    .rst_n        (rst_n),
    .zpos         (zpos),
    .zneg         (zneg),
    .za           (za),
    .mreq_n       (mreq_n),
    .iorq_n       (iorq_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .m1_n         (m1_n),
    .rfsh_n       (rfsh_n),
    .mrd_start    (mrd_start),
    .mwr_start    (mwr_start),
    .iord_start   (iord_start),
    .iowr_start   (iowr_start),
    .intack_start (intack_start),
    .rfsh_start   (rfsh_start),
    .cyc_end      (cyc_end),
    .opfetch      (opfetch),
    .cyc_addr     (cyc_addr),
    .busy         (busy)
  );

  function automatic logic [6:0] pulses();
    return {mrd_start, mwr_start, iord_start, iowr_start,
            intack_start, rfsh_start, cyc_end};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] b, input logic [ADDR_W-1:0] a);
    {mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n} = b;
    za = a;
  endtask

  // One sample of the bus. Returns with the registered pulses visible, then
  // checks that they are gone one fclk later. zsel = {zpos, zneg}.
  task automatic step(input string tag, input logic [5:0] b, input logic [ADDR_W-1:0] a,
                      input logic [6:0] exp_p, input logic [1:0] zsel = 2'b10);
    logic [6:0] got;
    @(negedge fclk);
    drive(b, a);
    {zpos, zneg} = zsel;
    @(negedge fclk);
    {zpos, zneg} = 2'b00;
    @(negedge fclk);
    got = pulses();
    chk(tag, {25'd0, got}, {25'd0, exp_p});
    @(negedge fclk);
    if (got != P_NONE) chk({tag, "_width"}, {25'd0, pulses()}, 32'd0);
    // keep a realistic gap between samples
    @(negedge fclk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    zpos  = 1'b0;
    zneg  = 1'b0;
    drive(B_IDLE, 16'h0000);
    repeat (3) @(negedge fclk);
    chk("rst_pulses",  {25'd0, pulses()}, 32'd0);
    chk("rst_busy",    {31'd0, busy}, 32'd0);
    chk("rst_opfetch", {31'd0, opfetch}, 32'd0);
    chk("rst_addr",    {16'd0, cyc_addr}, 32'd0);
    rst_n = 1'b1;

    step("arm", B_IDLE, 16'h0000, P_NONE);

    // plain memory read
    step("mrd_start", B_MRD, 16'h4000, P_MRD);
    chk("mrd_addr", {16'd0, cyc_addr}, 32'h4000);
    chk("mrd_opf",  {31'd0, opfetch}, 32'd0);
    chk("mrd_busy", {31'd0, busy}, 32'd1);
    step("mrd_hold", B_MRD, 16'h4000, P_NONE, 2'b01);
    step("mrd_end",  B_IDLE, 16'h4000, P_END);
    chk("mrd_idle_busy", {31'd0, busy}, 32'd0);

    // M1 fetch then refresh
    step("m1_start", B_M1RD, 16'h0038, P_MRD);
    chk("m1_opf",  {31'd0, opfetch}, 32'd1);
    chk("m1_addr", {16'd0, cyc_addr}, 32'h0038);
    step("m1_end", B_IDLE, 16'h0038, P_END, 2'b01);
    chk("m1_opf_clr", {31'd0, opfetch}, 32'd0);
    step("rfsh_start", B_RFSH, 16'h7F05, P_RFSH);
    chk("rfsh_addr", {16'd0, cyc_addr}, 32'h7F05);
    chk("rfsh_opf",  {31'd0, opfetch}, 32'd0);
    step("rfsh_end", B_IDLE, 16'h7F05, P_END, 2'b01);

    // memory write with late WR
    step("mwr_pend", B_MEM, 16'h8000, P_NONE);
    chk("mwr_pend_busy", {31'd0, busy}, 32'd0);
    step("mwr_start", B_MWR, 16'h8001, P_MWR, 2'b01);
    chk("mwr_addr", {16'd0, cyc_addr}, 32'h8001);
    chk("mwr_busy", {31'd0, busy}, 32'd1);
    step("mwr_end", B_IDLE, 16'h8001, P_END);

    // IO write, IO read, interrupt acknowledge (both z strobes at once)
    step("iowr_start", B_IOWR, 16'h00FE, P_IOWR);
    chk("iowr_addr", {16'd0, cyc_addr}, 32'h00FE);
    step("iowr_end",   B_IDLE, 16'h00FE, P_END);
    step("iord_start", B_IORD, 16'h00FE, P_IORD, 2'b11);
    step("iord_end",   B_IDLE, 16'h00FE, P_END);
    step("inta_start", B_INTA, 16'h00FF, P_INTA);
    chk("inta_addr", {16'd0, cyc_addr}, 32'h00FF);
    step("inta_end",   B_IDLE, 16'h00FF, P_END);

    // direct switch MEM_RD -> IO_RD
    step("sw_mrd",  B_MRD,  16'h1234, P_MRD);
    step("sw_iord", B_IORD, 16'h00FE, P_IORD | P_END);
    chk("sw_addr", {16'd0, cyc_addr}, 32'h00FE);
    step("sw_end",  B_IDLE, 16'h00FE, P_END);

    // reset in the middle of a read
    step("rm_mrd", B_MRD, 16'h5555, P_MRD);
    @(negedge fclk);
    rst_n = 1'b0;
    @(negedge fclk);
    chk("rm_pulses", {25'd0, pulses()}, 32'd0);
    chk("rm_busy",   {31'd0, busy}, 32'd0);
    chk("rm_addr",   {16'd0, cyc_addr}, 32'd0);
    rst_n = 1'b1;
    step("rm_unarmed1", B_MRD, 16'h5555, P_NONE);
    chk("rm_unarmed_busy", {31'd0, busy}, 32'd0);
    step("rm_unarmed2", B_MRD, 16'h5555, P_NONE, 2'b01);
    step("rm_arm",      B_IDLE, 16'h5555, P_NONE);
    step("rm_mrd2",     B_MRD, 16'h4000, P_MRD);
    chk("rm_addr2", {16'd0, cyc_addr}, 32'h4000);
    step("rm_end",      B_IDLE, 16'h4000, P_END);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
